// File: rtl/score_display_controller.sv
// score_display_controller: converts a binary score to BCD (double dabble) and commits the digits at the frame boundary
module score_display_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCORE_WIDTH = 14,
    parameter int MAX_SCORE   = 9999
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start_of_frame,
    input  logic                      i_score_valid,
    input  logic [SCORE_WIDTH-1:0]    i_score_in,
    output logic                      o_score_ready,
    output logic [4*NUM_DIGITS-1:0]   o_digits_out,
    output logic [NUM_DIGITS-1:0]     o_digit_enable,
    output logic                      o_overflow,
    output logic                      o_busy
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(SCORE_WIDTH + 1);
    localparam logic [SCORE_WIDTH-1:0] MAX_S = SCORE_WIDTH'(MAX_SCORE);
    localparam logic [CW-1:0] LAST = CW'(SCORE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, PENDING} state_t;

    state_t                 r_state;
    logic [SCORE_WIDTH-1:0] r_bin;
    logic [BW-1:0]          r_bcd;
    logic [CW-1:0]          r_cnt;
    logic                   r_sat;
    logic [BW-1:0]          w_adj;
    logic [NUM_DIGITS-1:0]  w_en;
    logic                   w_accept;
    logic                   w_sat;
    logic                   w_commit;

    assign o_score_ready = r_state != CONVERT;
    assign o_busy        = r_state != IDLE;
    assign w_accept      = i_score_valid && o_score_ready;
    assign w_sat         = i_score_in > MAX_S;
    assign w_commit      = r_state == PENDING && i_start_of_frame;

    // add 3 to every BCD nibble of 5 or more ahead of the shift
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++)
            w_adj[4*k +: 4] = r_bcd[4*k +: 4] >= 4'd5 ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
    end

    // a digit is shown if it or any more significant digit is nonzero; digit 0 always shows
    always_comb begin
        w_en = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            w_en[k] = (k == 0) || (|(r_bcd >> (4 * k)));
    end

    // handshake, conversion sequencing and frame-aligned commit of all digits together
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_bin          <= '0;
            r_bcd          <= '0;
            r_cnt          <= '0;
            r_sat          <= 1'b0;
            o_digits_out   <= '0;
            o_digit_enable <= NUM_DIGITS'(1);
            o_overflow     <= 1'b0;
        end else begin
            if (w_commit) begin
                o_digits_out   <= r_bcd;
                o_digit_enable <= w_en;
                o_overflow     <= r_sat;
            end
            if (w_accept) begin
                r_bin   <= w_sat ? MAX_S : i_score_in;
                r_sat   <= w_sat;
                r_bcd   <= '0;
                r_cnt   <= '0;
                r_state <= CONVERT;
            end else if (r_state == CONVERT) begin
                r_bcd   <= {w_adj[BW-2:0], r_bin[SCORE_WIDTH-1]};
                r_bin   <= r_bin << 1;
                r_cnt   <= r_cnt + 1'b1;
                r_state <= r_cnt == LAST ? PENDING : CONVERT;
            end else if (w_commit) begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_score_display_controller.sv
// tb_score_display_controller: directed scenarios for the score display controller
module tb_score_display_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sof = 1'b0;
    logic        valid = 1'b0;
    logic [13:0] score = '0;
    logic        ready;
    logic [15:0] digits;
    logic [3:0]  en;
    logic        ov;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    score_display_controller dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_start_of_frame(sof),
        .i_score_valid(valid),
        .i_score_in(score),
        .o_score_ready(ready),
        .o_digits_out(digits),
        .o_digit_enable(en),
        .o_overflow(ov),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [13:0] s);
        int budget;
        budget = 0;
        valid = 1'b1;
        score = s;
        while (!ready && budget < 40) begin
            tick(1);
            budget++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL send_timeout score=%0d ready=%b required 1", s, ready);
        end
        tick(1);
        valid = 1'b0;
    endtask

    task automatic frame();
        sof = 1'b1;
        tick(1);
        sof = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if ({digits, en, ov, busy, ready} !== {16'h0000, 4'b0001, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got d=%h en=%b ov=%b busy=%b rdy=%b required d=0000 en=0001 ov=0 busy=0 rdy=1", digits, en, ov, busy, ready);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_convert_1234();
        send(14'd1234);
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ready_low_cycle%0d got rdy=%b busy=%b required rdy=0 busy=1", i, ready, busy);
            end
            tick(1);
        end
        checks++;
        if (ready !== 1'b1 || busy !== 1'b1 || digits !== 16'h0000) begin
            errors++;
            $display("FAIL pending_1234 got rdy=%b busy=%b d=%h required rdy=1 busy=1 d=0000", ready, busy, digits);
        end
        tick(5);
        frame();
        checks++;
        if ({digits, en, ov, busy} !== {16'h1234, 4'b1111, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL commit_1234 got d=%h en=%b ov=%b busy=%b required d=1234 en=1111 ov=0 busy=0", digits, en, ov, busy);
        end
    endtask

    task automatic test_leading_zero();
        send(14'd7);
        tick(15);
        frame();
        checks++;
        if ({digits, en, ov} !== {16'h0007, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL commit_7 got d=%h en=%b ov=%b required d=0007 en=0001 ov=0", digits, en, ov);
        end
        send(14'd0);
        tick(15);
        frame();
        checks++;
        if ({digits, en, ov} !== {16'h0000, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL commit_0 got d=%h en=%b ov=%b required d=0000 en=0001 ov=0", digits, en, ov);
        end
    endtask

    task automatic test_saturation();
        send(14'd12000);
        tick(15);
        frame();
        checks++;
        if ({digits, en, ov} !== {16'h9999, 4'b1111, 1'b1}) begin
            errors++;
            $display("FAIL commit_12000 got d=%h en=%b ov=%b required d=9999 en=1111 ov=1", digits, en, ov);
        end
        send(14'd9999);
        tick(15);
        frame();
        checks++;
        if ({digits, en, ov} !== {16'h9999, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL commit_9999 got d=%h en=%b ov=%b required d=9999 en=1111 ov=0", digits, en, ov);
        end
    endtask

    task automatic test_frame_in_convert();
        send(14'd42);
        tick(4);
        frame();
        checks++;
        if ({digits, busy, ready} !== {16'h9999, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sof_in_convert got d=%h busy=%b rdy=%b required d=9999 busy=1 rdy=0", digits, busy, ready);
        end
        tick(12);
        checks++;
        if ({digits, busy, ready} !== {16'h9999, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL pending_42 got d=%h busy=%b rdy=%b required d=9999 busy=1 rdy=1", digits, busy, ready);
        end
        frame();
        checks++;
        if ({digits, en, ov, busy} !== {16'h0042, 4'b0011, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL commit_42 got d=%h en=%b ov=%b busy=%b required d=0042 en=0011 ov=0 busy=0", digits, en, ov, busy);
        end
    endtask

    task automatic test_back_to_back();
        send(14'd55);
        tick(15);
        send(14'd8888);
        checks++;
        if ({digits, busy, ready} !== {16'h0042, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart_8888 got d=%h busy=%b rdy=%b required d=0042 busy=1 rdy=0", digits, busy, ready);
        end
        tick(15);
        frame();
        checks++;
        if ({digits, en} !== {16'h8888, 4'b1111}) begin
            errors++;
            $display("FAIL commit_8888 got d=%h en=%b required d=8888 en=1111", digits, en);
        end
        send(14'd55);
        tick(15);
        sof = 1'b1;
        send(14'd8888);
        sof = 1'b0;
        checks++;
        if ({digits, en, busy, ready} !== {16'h0055, 4'b0011, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL commit_and_accept got d=%h en=%b busy=%b rdy=%b required d=0055 en=0011 busy=1 rdy=0", digits, en, busy, ready);
        end
        tick(15);
        frame();
        checks++;
        if ({digits, en} !== {16'h8888, 4'b1111}) begin
            errors++;
            $display("FAIL next_frame_8888 got d=%h en=%b required d=8888 en=1111", digits, en);
        end
    endtask

    task automatic test_reset_mid_convert();
        send(14'd1234);
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({digits, en, ov, busy, ready} !== {16'h0000, 4'b0001, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got d=%h en=%b ov=%b busy=%b rdy=%b required d=0000 en=0001 ov=0 busy=0 rdy=1", digits, en, ov, busy, ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(20);
        frame();
        checks++;
        if ({digits, en, busy} !== {16'h0000, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL no_commit_after_reset got d=%h en=%b busy=%b required d=0000 en=0001 busy=0", digits, en, busy);
        end
    endtask

    initial begin
        test_reset();
        test_convert_1234();
        test_leading_zero();
        test_saturation();
        test_frame_in_convert();
        test_back_to_back();
        test_reset_mid_convert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
